// File: rtl/riscv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: funct3 op codes,
// FSM states and small op-decoding helpers.
package riscv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic op_signed_src0(input md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_signed_src1(input md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative magnitude datapath: shift-add multiply into a 2N-bit accumulator or
// restoring shift-subtract divide, advancing one bit per step enable.
module muldiv_core #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           load,
  input  logic           step,
  input  logic           div_mode,
  input  logic [N-1:0]   lo_init,
  input  logic [N-1:0]   opnd,
  output logic [2*N-1:0] acc,
  output logic [N-1:0]   rem
);

  logic [2*N-1:0] acc_q;
  logic [N-1:0]   rem_q;
  logic [N-1:0]   opnd_q;
  logic           div_q;

  logic [N:0]     mul_sum;
  logic [N:0]     trial;
  logic [N+1:0]   diff;
  logic           fits;

  // Multiply: add the multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign mul_sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Divide: the low half holds dividend bits shifting out and quotient bits
  // shifting in; trial is the (N+1)-bit partial remainder.
  assign trial = {rem_q, acc_q[N-1]};
  assign diff  = {1'b0, trial} - {2'b00, opnd_q};
  assign fits  = ~diff[N+1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q  <= '0;
      rem_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else if (load) begin
      acc_q  <= {{N{1'b0}}, lo_init};
      rem_q  <= '0;
      opnd_q <= opnd;
      div_q  <= div_mode;
    end else if (step) begin
      if (div_q) begin
        acc_q[N-1:0] <= {acc_q[N-2:0], fits};
        rem_q        <= fits ? diff[N-1:0] : trial[N-1:0];
      end else begin
        acc_q <= {mul_sum, acc_q[N-1:1]};
      end
    end
  end

  assign acc = acc_q;
  assign rem = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M-style iterative multiply/divide unit with start/busy/done handshake.
// Define MULDIV_EARLY_OUT_EN to let trivial/special cases skip the CALC phase.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter  int N     = 32,
  localparam int CNT_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         md_start,
  input  logic [2:0]   md_op,
  input  logic [N-1:0] md_src0,
  input  logic [N-1:0] md_src1,
  output logic [N-1:0] md_result,
  output logic         md_busy,
  output logic         md_done,
  output logic         md_zero
);

  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  md_state_e state_q, state_d;
  md_op_e    op_in, op_q;

  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     src0_q;
  logic             a_neg_q, b_neg_q, div_zero_q, mul_zero_q, ovf_q;

  logic             accept, a_neg, b_neg, src1_zero, ovf_in;
  logic [N-1:0]     a_mag, b_mag;

  logic [2*N-1:0]   core_acc;
  logic [N-1:0]     core_rem;
  logic [2*N-1:0]   prod;
  logic [N-1:0]     quot, rem, fix_result;

  assign op_in     = md_op_e'(md_op);
  assign accept    = (state_q == MD_IDLE) && md_start;
  assign a_neg     = op_signed_src0(op_in) & md_src0[N-1];
  assign b_neg     = op_signed_src1(op_in) & md_src1[N-1];
  assign a_mag     = a_neg ? -md_src0 : md_src0;
  assign b_mag     = b_neg ? -md_src1 : md_src1;
  assign src1_zero = (md_src1 == '0);
  assign ovf_in    = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                     (md_src0 == MIN_NEG) && (md_src1 == '1);

  muldiv_core #(.N(N)) u_core (
    .clk      (clk),
    .rstn     (rstn),
    .load     (accept),
    .step     (state_q == MD_CALC),
    .div_mode (op_is_div(op_in)),
    .lo_init  (op_is_div(op_in) ? a_mag : b_mag),
    .opnd     (op_is_div(op_in) ? b_mag : a_mag),
    .acc      (core_acc),
    .rem      (core_rem)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
`ifdef MULDIV_EARLY_OUT_EN
          state_d = (src1_zero || ovf_in) ? MD_FIX : MD_CALC;
`else
          state_d = MD_CALC;
`endif
        end
      end
      MD_CALC: if (cnt_q == '0) state_d = MD_FIX;
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      op_q       <= MD_MUL;
      src0_q     <= '0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      mul_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (accept) begin
      cnt_q      <= CNT_W'(N-1);
      op_q       <= op_in;
      src0_q     <= md_src0;
      a_neg_q    <= a_neg;
      b_neg_q    <= b_neg;
      div_zero_q <= src1_zero & op_is_div(op_in);
      mul_zero_q <= src1_zero & ~op_is_div(op_in);
      ovf_q      <= ovf_in;
    end else if (state_q == MD_CALC && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Sign correction on magnitudes, then the architectural special cases,
  // which also cover the early-out path where the core never ran.
  always_comb begin
    prod = (a_neg_q ^ b_neg_q) ? -core_acc : core_acc;
    quot = (a_neg_q ^ b_neg_q) ? -core_acc[N-1:0] : core_acc[N-1:0];
    rem  = a_neg_q ? -core_rem : core_rem;
    fix_result = '0;
    case (op_q)
      MD_MUL:                      fix_result = prod[N-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_result = prod[2*N-1:N];
      MD_DIV, MD_DIVU:             fix_result = div_zero_q ? '1 : (ovf_q ? src0_q : quot);
      MD_REM, MD_REMU:             fix_result = div_zero_q ? src0_q : (ovf_q ? '0 : rem);
      default:                     fix_result = '0;
    endcase
    if (mul_zero_q) fix_result = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      md_result <= '0;
      md_done   <= 1'b0;
    end else begin
      md_done <= (state_q == MD_FIX);
      if (state_q == MD_FIX) md_result <= fix_result;
    end
  end

  assign md_busy = (state_q != MD_IDLE);
  assign md_zero = ~|md_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (N=32): results, latency,
// special cases, handshake and mid-operation reset.
module tb_muldiv_unit;
  import riscv_pkg::*;

  localparam int N       = 32;
  localparam int FULL_LAT = N + 1;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = N + 1;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         md_start = 1'b0;
  logic [2:0]   md_op = 3'b000;
  logic [N-1:0] md_src0 = '0;
  logic [N-1:0] md_src1 = '0;
  logic [N-1:0] md_result;
  logic         md_busy, md_done, md_zero;

  int checks = 0;
  int errors = 0;
  int lat;
  int done_cnt;

  muldiv_unit #(.N(N)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .md_start  (md_start),
    .md_op     (md_op),
    .md_src0   (md_src0),
    .md_src1   (md_src1),
    .md_result (md_result),
    .md_busy   (md_busy),
    .md_done   (md_done),
    .md_zero   (md_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request and returns just after the capture edge, start still high.
  task automatic start_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    md_start = 1'b1;
    md_op    = op;
    md_src0  = a;
    md_src1  = b;
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the capture edge until md_done, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!md_done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [N-1:0] exp, input int exp_lat);
    int n;
    start_op(op, a, b);
    @(negedge clk);
    md_start = 1'b0;
    md_op    = 3'($urandom);
    md_src0  = $urandom;
    md_src1  = $urandom;
    wait_done(n);
    check({tag, " result"}, md_result, exp);
    check({tag, " latency"}, n, exp_lat);
    check({tag, " zero"}, 32'(md_zero), 32'(exp == '0));
    @(posedge clk);
    #1;
    check({tag, " done width"}, 32'(md_done), 32'd0);
  endtask

  initial begin
    #12;
    check("reset result", md_result, 32'h0);
    check("reset busy", 32'(md_busy), 32'd0);
    check("reset done", 32'(md_done), 32'd0);
    check("reset zero", 32'(md_zero), 32'd1);
    @(negedge clk);
    rstn = 1'b1;

    run_op("mulhu max", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, FULL_LAT);
    run_op("mul max",   MD_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, FULL_LAT);
    run_op("mulh -1*2", MD_MULH,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, FULL_LAT);
    run_op("mulhsu",    MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, FULL_LAT);
    run_op("mulh min*min", MD_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, FULL_LAT);
    run_op("mul by zero", MD_MUL, 32'h0000_1234, 32'h0, 32'h0, SPEC_LAT);
    run_op("div -7/2",  MD_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, FULL_LAT);
    run_op("rem -7/2",  MD_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, FULL_LAT);
    run_op("divu 100/7", MD_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT);
    run_op("remu 100/7", MD_REMU, 32'd100, 32'd7, 32'd2, FULL_LAT);
    run_op("div 5/0",   MD_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    run_op("remu 5/0",  MD_REMU, 32'd5, 32'd0, 32'd5, SPEC_LAT);
    run_op("div -5/0",  MD_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    run_op("rem -5/0",  MD_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPEC_LAT);
    run_op("div ovf",   MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
    run_op("rem ovf",   MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SPEC_LAT);

    // Start held through the whole operation with different operands: the
    // busy-time requests are ignored, the one seen in the done cycle is taken.
    start_op(MD_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    md_op   = MD_MUL;
    md_src0 = 32'd3;
    md_src1 = 32'd5;
    wait_done(lat);
    check("held first result", md_result, 32'd14);
    check("held first latency", lat, FULL_LAT);
    @(posedge clk);
    #1;
    check("b2b accepted busy", 32'(md_busy), 32'd1);
    check("b2b done width", 32'(md_done), 32'd0);
    @(negedge clk);
    md_start = 1'b0;
    wait_done(lat);
    check("b2b second result", md_result, 32'd15);
    check("b2b second latency", lat, FULL_LAT);

    // Reset during CALC aborts at once and produces no done pulse.
    start_op(MD_MULHU, 32'hFFFF_FFFF, 32'h0000_0003);
    @(negedge clk);
    md_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid busy before rst", 32'(md_busy), 32'd1);
    rstn = 1'b0;
    #1;
    check("mid rst result", md_result, 32'h0);
    check("mid rst busy", 32'(md_busy), 32'd0);
    check("mid rst done", 32'(md_done), 32'd0);
    check("mid rst zero", 32'(md_zero), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    done_cnt = 0;
    repeat (N + 8) begin
      @(posedge clk);
      #1;
      if (md_done) done_cnt++;
    end
    check("mid rst no done", done_cnt, 32'd0);
    run_op("after rst divu", MD_DIVU, 32'd1000, 32'd10, 32'd100, FULL_LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M-style multiply/divide unit; parametrised companion to the combinational ALU in the execute stage.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over N-bit operands, one bit per cycle.
- Start/busy/done handshake lets the control FSM stall the pipeline while the unit runs.
- Exposes a zero flag with the same meaning as the ALU zero flag.

Parameters:
- N, 32, operand/result width in bits (N >= 4, even).
- CNT_W, $clog2(N), width of the iteration counter (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- md_start  input  1  request; sampled only when md_busy=0.
- md_op  input  3  operation, RISC-V funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- md_src0  input  N  rs1 operand (multiplicand/dividend).
- md_src1  input  N  rs2 operand (multiplier/divisor).
- md_result  output  N  registered result; holds its value until the next completion.
- md_busy  output  1  high while an operation is in flight.
- md_done  output  1  one-cycle pulse when md_result updates.
- md_zero  output  1  ~|md_result.

Behaviour:
- Clock and reset: one clock domain; rstn asynchronous, active-low.
- Reset values: state IDLE, md_result=0, md_busy=0, md_done=0, md_zero=1, counter=0. Reset mid-operation aborts the operation; no done pulse follows.
- States:
  - IDLE: md_start=1 latches op, captures operand magnitudes/sign flags, goes to CALC.
  - CALC: exactly N cycles with the counter running N-1 down to 0, then FIX.
  - FIX: sign correction and result select, write md_result, set md_done=1 for the following cycle, go to IDLE.
- md_busy = (state != IDLE), combinational from the state register.
- Latency: if md_start is sampled at edge T, md_result and md_done are valid in the cycle after edge T+N+1. For N=32 that is 34 cycles from request to result.
- Back-to-back: md_start asserted in the md_done cycle is accepted, since the unit is in IDLE.
- md_start while busy: ignored, no effect. Operands and md_op are don't-care after the capture edge.
- Sign rules:
  - MULH: both operands signed. MULHSU: src0 signed, src1 unsigned. MULHU, DIVU, REMU: unsigned.
  - Magnitude-based core: multiply uses a 2N-bit shift-add accumulator; divide uses restoring shift-subtract with an (N+1)-bit partial remainder.
  - Product negated if exactly one signed operand is negative. Quotient negated if the signs differ. Remainder takes the dividend's sign.
- Result select: MUL takes the low N bits, MULH* the high N bits, DIV* the quotient, REM* the remainder.
- Divide by zero: quotient = all ones (DIV and DIVU), remainder = src0.
- Signed overflow (src0 = -2^(N-1), src1 = -1, DIV/REM): quotient = src0, remainder = 0.
- md_done is high for exactly one cycle per accepted start.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: divide-by-zero, signed overflow, and operations with src1 = 0 (MUL*) skip CALC. IDLE goes straight to FIX, so md_done follows start after 2 edges. Results are identical to the non-early path.
- Undefined: every operation takes the full N+2-cycle latency; special cases are resolved in FIX only. Cycle counts are deterministic.

Decomposition:
- Shared package (riscv_pkg) holds:
  - md_op encodings MD_MUL..MD_REMU.
  - State encodings MD_IDLE/MD_CALC/MD_FIX.
- One natural sub-module: muldiv_core, the iterative datapath (accumulator, partial remainder, one step per enable). The top level keeps the FSM, sign handling and special cases.

Test Plan:
- Reset mid-operation: reset asserted during CALC (N=32) -> all outputs at reset values at once, no done pulse; next start completes normally.
- Multiply high: MULHU 0xFFFFFFFF*0xFFFFFFFF -> md_result=0xFFFFFFFE, done exactly 34 cycles after start; MUL same operands -> 0x00000001.
- Signed multiply: MULH 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14 with md_zero=0.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- Signed overflow: DIV 0x80000000/-1 -> 0x80000000; REM same operands -> 0 with md_zero=1.
- Handshake: start held during busy -> ignored; start in done cycle -> second result after another 34 cycles. With MULDIV_EARLY_OUT_EN: DIV by 0 completes in 2 cycles.
